ifetch_prefetch: RTL and testbench

- Instruction-fetch front end feeding the IF stage of the five-stage pipeline.
- Replaces the zero-latency instruction ROM with a handshaked instruction bus and a small prefetch FIFO of sequential words.
- Presents the word at the core's current PC as the IF-stage instruction and raises a fetch stall when that word is not yet available.
- Detects redirects (taken branch/jump) by PC mismatch, then flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifetch_prefetch_if.sv | 39 +++
 rtl/ifetch_prefetch.sv | 240 ++++++++++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_if.sv
// Instruction bus between the fetch front end (master) and the instruction
// memory or bus fabric (slave).
//
// Signals:
//   req_valid  master -> slave  read request valid
//   req_addr   master -> slave  word-aligned read address
//   req_ready  slave  -> master request accepted this cycle
//   rsp_valid  slave  -> master read data valid (in request order)
//   rsp_data   slave  -> master read data
//
// Handshake: a request transfers on every rising edge where req_valid and
// req_ready are both 1. Once req_valid is raised, req_valid and req_addr stay
// constant until that transfer happens; req_ready may change freely and may
// depend on req_valid. Responses have no backpressure: each cycle with
// rsp_valid=1 delivers exactly one word, in the order the requests were
// accepted, and never in the same cycle the request was accepted.
interface ifetch_prefetch_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end for the IF stage of the five-stage pipeline.
// Prefetches sequential words over a handshaked instruction bus into a small
// FIFO, presents the word at the core's PC, and stalls the core when that word
// is not yet available. A PC that differs from the next expected address is a
// redirect (taken branch or jump): the FIFO is flushed, every response still
// owed by the bus is marked stale and dropped, and fetching restarts at the
// new PC.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-low reset
//   pc            PC requested by the IF stage (pc[1:0] ignored)
//   advance       IF stage consumes the presented instruction this cycle
//   instr         word at pc when instr_valid, otherwise NOP
//   instr_valid   instr is the correct word for pc
//   fetch_stall   ~instr_valid, ORed into the core's stall
//   flush_count   number of redirects seen (wraps)
//   stall_cycles  number of cycles with fetch_stall=1 out of reset (wraps)
//   bus           instruction bus, master side
module ifetch_prefetch #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] NOP             = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               pc,
    input  logic                      advance,
    output logic [31:0]               instr,
    output logic                      instr_valid,
    output logic                      fetch_stall,
    output logic [31:0]               flush_count,
    output logic [31:0]               stall_cycles,
    ifetch_prefetch_if.master         bus
);

    localparam int PW = $clog2(DEPTH);
    // Counters share one width wide enough for DEPTH entries and for
    // MAX_OUTSTANDING+1 (MAX_OUTSTANDING never exceeds DEPTH).
    localparam int CW = $clog2(DEPTH + 2);

    localparam logic [CW-1:0] MAX_C   = MAX_OUTSTANDING[CW-1:0];
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    // Address the next pushed word belongs to; equals expected_pc when the
    // FIFO is empty.
    logic [31:0]   tail_addr_q;
    logic [31:0]   next_req_addr_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic          req_valid_q;
    logic [31:0]   req_addr_q;
    // The request currently held on the bus was raised before a redirect;
    // its response must be dropped once it is accepted.
    logic          req_stale_q;
    logic [31:0]   flush_count_q;
    logic [31:0]   stall_cycles_q;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [31:0]   pc_aligned;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;
    logic [31:0]   expected_pc;
    logic          fifo_empty;
    logic          redirect;
    logic          hit;
    logic          pop;
    logic          push;
    logic          accept;
    logic          slot_free;
    logic          issue;
    logic [31:0]   issue_addr;
    logic [CW-1:0] count_next;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard_next;
    logic          req_stale_next;
    logic [CW:0]   reserve_sum;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^pc[1:0];

    always_comb begin
        pc_aligned  = {pc[31:2], 2'b00};
        head_addr   = addr_mem[rd_ptr_q];
        head_data   = data_mem[rd_ptr_q];
        fifo_empty  = (count_q == '0);
        expected_pc = fifo_empty ? tail_addr_q : head_addr;
        redirect    = (pc_aligned != expected_pc);
        // With a non-empty FIFO, hit and redirect are mutually exclusive
        // because expected_pc is the head address; the !redirect term keeps
        // the intent explicit.
        hit         = !fifo_empty && (head_addr == pc_aligned) && !redirect;
        pop         = hit && advance;
        accept      = req_valid_q && bus.req_ready;
        // A response is live only when nothing stale is still owed and the
        // stream is not being redirected in this same cycle.
        push        = bus.rsp_valid && !redirect && (discard_q == '0);
    end

    always_comb begin
        outstanding_next = outstanding_q + CW'(accept) - CW'(bus.rsp_valid);
        count_next       = count_q;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count_q + CW'(push) - CW'(pop);
        end
    end

    // Stale-response bookkeeping. On a redirect every response still owed
    // after the edge is stale. A request that is still waiting for
    // req_ready at the redirect is not yet owed, so it is flagged and added
    // to discard when it is finally accepted.
    always_comb begin
        discard_next   = discard_q;
        req_stale_next = req_stale_q;
        if (redirect) begin
            discard_next = outstanding_next;
        end else begin
            discard_next = discard_q
                         - CW'(bus.rsp_valid && (discard_q != '0))
                         + CW'(accept && req_stale_q);
        end
        if (accept) begin
            req_stale_next = 1'b0;
        end
        if (redirect && req_valid_q && !bus.req_ready) begin
            req_stale_next = 1'b1;
        end
    end

    // Request issue. The space check reserves a FIFO slot for every request
    // in flight, so a returning response always has room. On a redirect the
    // first request for the new PC goes out at the same edge so the target
    // word can be presented three cycles after the mismatch.
    always_comb begin
        slot_free   = !req_valid_q || accept;
        reserve_sum = {1'b0, count_next} + {1'b0, outstanding_next};
        issue       = slot_free
                   && (reserve_sum < DEPTH_W)
                   && (outstanding_next < MAX_C);
        issue_addr  = redirect ? pc_aligned : next_req_addr_q;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= tail_addr_q;
            data_mem[wr_ptr_q] <= bus.rsp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            tail_addr_q     <= '0;
            next_req_addr_q <= '0;
            outstanding_q   <= '0;
            discard_q       <= '0;
            req_valid_q     <= 1'b0;
            req_addr_q      <= '0;
            req_stale_q     <= 1'b0;
            flush_count_q   <= '0;
            stall_cycles_q  <= '0;
        end else begin
            count_q        <= count_next;
            outstanding_q  <= outstanding_next;
            discard_q      <= discard_next;
            req_stale_q    <= req_stale_next;
            stall_cycles_q <= stall_cycles_q + {31'b0, fetch_stall};

            if (redirect) begin
                rd_ptr_q      <= '0;
                wr_ptr_q      <= '0;
                tail_addr_q   <= pc_aligned;
                flush_count_q <= flush_count_q + 32'd1;
            end else begin
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (push) begin
                    wr_ptr_q    <= wr_ptr_q + PW'(1);
                    tail_addr_q <= tail_addr_q + 32'd4;
                end
            end

            if (issue) begin
                req_valid_q     <= 1'b1;
                req_addr_q      <= issue_addr;
                next_req_addr_q <= issue_addr + 32'd4;
            end else begin
                if (accept) begin
                    req_valid_q <= 1'b0;
                end
                if (redirect) begin
                    next_req_addr_q <= pc_aligned;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr         = hit ? head_data : NOP;
    assign instr_valid   = hit;
    assign fetch_stall   = ~hit;
    assign flush_count   = flush_count_q;
    assign stall_cycles  = stall_cycles_q;
    assign bus.req_valid = req_valid_q;
    assign bus.req_addr  = req_addr_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_q == DEPTH_C)));

    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!reset)
        !(bus.rsp_valid && (outstanding_q == '0)));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (!reset)
        outstanding_q <= MAX_C);

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        advance;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_stall;
    logic [31:0] flush_count;
    logic [31:0] stall_cycles;

    ifetch_prefetch_if bus_if ();

    ifetch_prefetch #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .NOP             (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .advance      (advance),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .fetch_stall  (fetch_stall),
        .flush_count  (flush_count),
        .stall_cycles (stall_cycles),
        .bus          (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    logic [31:0] exp_q [$];     // expected word for the PC currently driven
    logic [31:0] acc_q [$];     // addresses accepted by the bus, in order
    logic [31:0] bq_addr [$];   // bus model: accepted, not yet responded
    int          bq_due [$];
    int          cyc = 0;
    int          rsp_lat = 1;
    bit          rsp_hold = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- bus responder ----------------
    // Data returned for an address is the address itself.
    initial begin : bus_model
        logic        acc;
        logic [31:0] acc_a;
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc   = reset && bus_if.req_valid && bus_if.req_ready;
            acc_a = bus_if.req_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                bq_addr.delete();
                bq_due.delete();
                bus_if.rsp_valid = 1'b0;
            end else begin
                if (acc) begin
                    bq_addr.push_back(acc_a);
                    bq_due.push_back(cyc + rsp_lat - 1);
                    acc_q.push_back(acc_a);
                end
                if (!rsp_hold && bq_addr.size() > 0 && bq_due[0] <= cyc) begin
                    bus_if.rsp_valid = 1'b1;
                    bus_if.rsp_data  = bq_addr.pop_front();
                    void'(bq_due.pop_front());
                end else begin
                    bus_if.rsp_valid = 1'b0;
                    bus_if.rsp_data  = '0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One core cycle: check outputs at the negedge, then update pc after the
    // next rising edge if the instruction was consumed.
    task automatic run_core(input int n, input bit stream_chk);
        bit consumed;
        bit want_stall;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            want_stall = !instr_valid;
            chk("fetch_stall", fetch_stall, want_stall);
            if (stream_chk) chk("stream_valid", instr_valid, 1'b1);
            if (instr_valid) chk("instr", instr, exp_q[0]);
            else             chk("instr_nop", instr, NOP);
            consumed = instr_valid && advance;
            @(posedge clk);
            #1;
            if (consumed) begin
                void'(exp_q.pop_front());
                pc = pc + 32'd4;
                exp_q.push_back(pc);
                pops++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_at(input logic [31:0] start_pc, input logic adv);
        pc      = start_pc;
        advance = adv;
        exp_q.delete();
        exp_q.push_back(start_pc);
        acc_q.delete();
        pops    = 0;
        reset   = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, bus_if.req_valid, 1'b0);
        chk({tag, "_req_addr"}, bus_if.req_addr, 32'h0);
        chk({tag, "_instr_valid"}, instr_valid, 1'b0);
        chk({tag, "_fetch_stall"}, fetch_stall, 1'b1);
        chk({tag, "_instr"}, instr, NOP);
        chk({tag, "_flush_count"}, flush_count, 32'h0);
        chk({tag, "_stall_cycles"}, stall_cycles, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        pc = '0;
        advance = 1'b0;
        bus_if.req_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");

        // --- sequential stream from reset, bus always ready, 1-cycle rsp ---
        @(posedge clk);
        #1;
        release_at(32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                chk("t1_req_valid", bus_if.req_valid, 1'b1);
                chk("t1_req_addr", bus_if.req_addr, 32'((i - 1) * 4));
            end
            chk("t1_first_valid", instr_valid, (i == 3));
        end
        chk("t1_first_instr", instr, exp_q[0]);
        chk("t1_stall_cycles", stall_cycles, 32'd3);
        @(posedge clk);
        #1;
        void'(exp_q.pop_front());
        pc = 32'h4;
        exp_q.push_back(pc);
        run_core(16, 1'b1);
        chk("t1_stall_after", stall_cycles, 32'd3);
        chk("t1_flush", flush_count, 32'd0);
        for (int k = 0; k < acc_q.size(); k++) chk("t1_req_seq", acc_q[k], 32'(k * 4));

        // --- full FIFO with advance held low ---
        do_reset();
        release_at(32'h0, 1'b0);
        run_core(12, 1'b0);
        chk("t2_req_count", 32'(acc_q.size()), 32'd4);
        @(negedge clk);
        chk("t2_req_idle", bus_if.req_valid, 1'b0);
        chk("t2_head_valid", instr_valid, 1'b1);
        chk("t2_head_instr", instr, 32'h0);
        @(posedge clk);
        #1;
        advance = 1'b1;
        run_core(6, 1'b1);
        advance = 1'b0;
        run_core(8, 1'b0);
        chk("t2_pops", 32'(pops), 32'd6);
        chk("t2_refill_count", 32'(acc_q.size()), 32'd10);
        for (int k = 0; k < acc_q.size(); k++) chk("t2_req_seq", acc_q[k], 32'(k * 4));

        // --- redirect 0x8 -> 0x100 with two requests outstanding ---
        do_reset();
        release_at(32'h0, 1'b1);
        for (int k = 0; k < 20 && pc != 32'h8; k++) run_core(1, 1'b0);
        chk("t3_reach_pc8", pc, 32'h8);
        advance  = 1'b0;
        rsp_hold = 1'b1;
        run_core(4, 1'b0);
        chk("t3_outstanding", 32'(bq_addr.size()), 32'd2);
        pc = 32'h100;
        exp_q.delete();
        exp_q.push_back(pc);
        advance = 1'b1;
        pops = 0;
        run_core(1, 1'b0);
        rsp_hold = 1'b0;
        run_core(12, 1'b0);
        chk("t3_flush", flush_count, 32'd1);
        chk("t3_progress", 32'(pops >= 4), 32'd1);

        // --- backpressure across a redirect ---
        do_reset();
        bus_if.req_ready = 1'b0;
        release_at(32'h0, 1'b0);
        run_core(2, 1'b0);
        pc = 32'h100;
        exp_q.delete();
        exp_q.push_back(pc);
        advance = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", bus_if.req_valid, 1'b1);
            chk("t4_hold_addr", bus_if.req_addr, 32'h0);
            chk("t4_hold_instr_valid", instr_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        bus_if.req_ready = 1'b1;
        run_core(10, 1'b0);
        chk("t4_acc0", acc_q[0], 32'h0);
        chk("t4_acc1", acc_q[1], 32'h100);
        chk("t4_flush", flush_count, 32'd1);
        chk("t4_progress", 32'(pops >= 3), 32'd1);

        // --- address wrap ---
        do_reset();
        release_at(32'hFFFF_FFF8, 1'b1);
        run_core(12, 1'b0);
        chk("t5_acc0", acc_q[0], 32'hFFFF_FFF8);
        chk("t5_acc1", acc_q[1], 32'hFFFF_FFFC);
        chk("t5_acc2", acc_q[2], 32'h0);
        chk("t5_flush", flush_count, 32'd1);
        chk("t5_progress", 32'(pops >= 4), 32'd1);

        // --- asynchronous reset mid-stream with two outstanding ---
        rsp_hold = 1'b1;
        run_core(4, 1'b0);
        chk("t6_outstanding", 32'(bq_addr.size()), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("t6");
        rsp_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        release_at(32'h0, 1'b1);
        run_core(8, 1'b0);
        chk("t6_recover", 32'(pops >= 3), 32'd1);
        chk("t6_flush", flush_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
